// File: rtl/delay_ctrl_source.sv
// ---------------------------------------------------------------------------
// delay_ctrl_source
//
// Fabric-side driver for the HPS PIO input "delay_ctrl_export" on soc_system.
// An asynchronous, active-low pushbutton is synchronised, debounced and turned
// into a glitch-free level that stays high long enough for HPS software that
// polls the PIO to see every press. Accepted presses are counted for LEDs.
//
// Build option:
//   DELAY_CTRL_TOGGLE_EN  when defined, delay_ctrl_export becomes a toggle
//                         register that inverts once per accepted press.
//                         When undefined (default), delay_ctrl_export is high
//                         in HOLD, WAIT_REL and DEB_REL.
//
// Parameters:
//   SYNC_STAGES      flops in the key_n synchroniser (>= 2)
//   DEBOUNCE_CYCLES  stable-level cycles needed to accept a press or release
//   HOLD_CYCLES      minimum cycles the output stays high per press
//   CNT_W            timer width; holds max(DEBOUNCE_CYCLES,HOLD_CYCLES)-1
//
// Ports:
//   clk_clk            in   1  system clock, rising edge
//   reset_reset        in   1  synchronous reset, active-high
//   key_n              in   1  pushbutton, asynchronous, 0 = pressed
//   delay_ctrl_export  out  1  level to the soc_system PIO input
//   press_count        out  8  accepted presses, modulo 256
//   busy               out  1  high whenever the FSM is not in IDLE
//
// Handshake: there is no valid/ready pair on this block; key_n is a free
// running level and every output is a registered level that is meaningful
// on every cycle.
//
// Timing (all outputs registered together with the state):
//   export rises DEBOUNCE_CYCLES+1 cycles after key_s first reads 0.
//   Once high, export stays high for HOLD_CYCLES (HOLD) plus at least one
//   WAIT_REL cycle plus DEBOUNCE_CYCLES (DEB_REL), even for a short press.
// ---------------------------------------------------------------------------
module delay_ctrl_source #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int HOLD_CYCLES     = 500000,
    parameter int CNT_W           = 20
) (
    input  logic       clk_clk,
    input  logic       reset_reset,
    input  logic       key_n,
    output logic       delay_ctrl_export,
    output logic [7:0] press_count,
    output logic       busy
);

    // Terminal timer values for the two timed phases.
    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        DEB_PRESS = 3'd1,
        HOLD      = 3'd2,
        WAIT_REL  = 3'd3,
        DEB_REL   = 3'd4
    } state_t;

    // -----------------------------------------------------------------------
    // Synchroniser. Resets to all ones (button released) so that a key held
    // through reset is seen as a fresh falling edge SYNC_STAGES cycles later.
    // -----------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   key_s;

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], key_n};
        end
    end

    assign key_s = sync_q[SYNC_STAGES-1];

    // -----------------------------------------------------------------------
    // FSM state, timer and registered outputs
    // -----------------------------------------------------------------------
    state_t           state_q;
    state_t           state_nxt;
    logic [CNT_W-1:0] timer_q;
    logic [CNT_W-1:0] timer_nxt;
    logic             accept;      // DEB_PRESS -> HOLD this cycle
    logic             export_nxt;
    logic             busy_nxt;
    logic [7:0]       count_nxt;

    // Debug view of the FSM state for checkers bound to this block.
    state_t           dbg_state;
    assign dbg_state = state_q;

    // Process 1: state register. Outputs are registered alongside the state
    // so every output changes on the same edge as the state it reflects.
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            state_q           <= IDLE;
            timer_q           <= '0;
            delay_ctrl_export <= 1'b0;
            press_count       <= 8'd0;
            busy              <= 1'b0;
        end else begin
            state_q           <= state_nxt;
            timer_q           <= timer_nxt;
            delay_ctrl_export <= export_nxt;
            press_count       <= count_nxt;
            busy              <= busy_nxt;
        end
    end

    // Process 2: next-state and timer logic.
    always_comb begin
        state_nxt = state_q;
        timer_nxt = timer_q;
        accept    = 1'b0;

        case (state_q)
            IDLE: begin
                if (!key_s) begin
                    state_nxt = DEB_PRESS;
                    timer_nxt = '0;
                end
            end

            DEB_PRESS: begin
                // Any high read during debounce is a bounce: drop it silently.
                if (key_s) begin
                    state_nxt = IDLE;
                    timer_nxt = '0;
                end else if (timer_q == DEB_LAST) begin
                    state_nxt = HOLD;
                    timer_nxt = '0;
                    accept    = 1'b1;
                end else begin
                    timer_nxt = timer_q + CNT_W'(1);
                end
            end

            HOLD: begin
                // The key is deliberately ignored here; this phase guarantees
                // the minimum high time and the lockout against new presses.
                if (timer_q == HOLD_LAST) begin
                    state_nxt = WAIT_REL;
                    timer_nxt = '0;
                end else begin
                    timer_nxt = timer_q + CNT_W'(1);
                end
            end

            WAIT_REL: begin
                if (key_s) begin
                    state_nxt = DEB_REL;
                    timer_nxt = '0;
                end
            end

            DEB_REL: begin
                // A low read means the release bounced; go back and wait for
                // the key to come up again without disturbing the output.
                if (!key_s) begin
                    state_nxt = WAIT_REL;
                    timer_nxt = '0;
                end else if (timer_q == DEB_LAST) begin
                    state_nxt = IDLE;
                    timer_nxt = '0;
                end else begin
                    timer_nxt = timer_q + CNT_W'(1);
                end
            end

            default: begin
                state_nxt = IDLE;
                timer_nxt = '0;
            end
        endcase
    end

    // Process 3: output logic. Values computed here are the outputs for the
    // state being entered, and are captured by the state register.
    always_comb begin
        busy_nxt  = (state_nxt != IDLE);
        count_nxt = press_count + {7'd0, accept};
`ifdef DELAY_CTRL_TOGGLE_EN
        export_nxt = delay_ctrl_export ^ accept;
`else
        export_nxt = (state_nxt == HOLD) ||
                     (state_nxt == WAIT_REL) ||
                     (state_nxt == DEB_REL);
`endif
    end

endmodule

// File: tb/tb_delay_ctrl_source.sv
// ---------------------------------------------------------------------------
// tb_delay_ctrl_source
//
// Bench for delay_ctrl_source with SYNC_STAGES=2, DEBOUNCE_CYCLES=4,
// HOLD_CYCLES=8. Each scenario is a per-cycle key_n waveform. A reference
// model walks the waveform phase by phase (search for a low read, require a
// run of stable reads, fixed hold window, search for a stable release) and
// produces the expected {export, busy, press_count} for every cycle. The
// driver applies key_n on the falling clock edge and pushes the expected
// triple; the monitor pops and compares 1 time unit after the rising edge.
// Honours DELAY_CTRL_TOGGLE_EN for the toggle build.
// ---------------------------------------------------------------------------
module tb_delay_ctrl_source;

    localparam int S = 2;
    localparam int D = 4;
    localparam int H = 8;

    // ---------------- clock / reset ----------------
    logic       clk   = 1'b0;
    logic       rst   = 1'b1;
    logic       key_n = 1'b1;
    logic       dce;
    logic [7:0] pc;
    logic       busy;

    always #5 clk = ~clk;

    delay_ctrl_source #(
        .SYNC_STAGES     (S),
        .DEBOUNCE_CYCLES (D),
        .HOLD_CYCLES     (H),
        .CNT_W           (4)
    ) dut (
        .clk_clk           (clk),
        .reset_reset       (rst),
        .key_n             (key_n),
        .delay_ctrl_export (dce),
        .press_count       (pc),
        .busy              (busy)
    );

    // ---------------- scoreboard state ----------------
    logic       wave[$];
    logic [9:0] exp_arr[$];
    logic [9:0] exp_q[$];
    int         n_checks = 0;
    int         n_pass   = 0;
    int         m_count  = 0;
    logic       m_tog    = 1'b0;
    string      scen     = "none";
    int         cyc      = 0;

    function automatic logic [9:0] pack(logic e, logic b, int c);
        logic [7:0] c8;
        c8 = 8'(c);
        return {e, b, c8};
    endfunction

    task automatic check(string name, logic [9:0] got, logic [9:0] want);
        n_checks++;
        if (got === want) begin
            n_pass++;
        end else begin
            $display("FAIL %s cyc=%0d: got export=%0b busy=%0b count=%0d, want export=%0b busy=%0b count=%0d",
                     name, cyc, got[9], got[8], got[7:0], want[9], want[8], want[7:0]);
        end
    endtask

    // ---------------- reference model ----------------
    // u[i] is the synchronised key the FSM reads at step i (step i ends on the
    // edge that samples wave[i]); before the waveform the key reads released.
    task automatic build_expected();
        int n;
        int u[];
        int hi[];
        int bz[];
        int acc[];
        int t, start, run, h, w, s, k;
        bit done;
        logic e;
        n   = wave.size();
        u   = new[n];
        hi  = new[n];
        bz  = new[n];
        acc = new[n];
        for (int i = 0; i < n; i++) begin
            u[i]   = (i >= S) ? int'(wave[i-S]) : 1;
            hi[i]  = 0;
            bz[i]  = 0;
            acc[i] = 0;
        end
        t = 0;
        while (t < n) begin
            while (t < n && u[t] == 1) t++;
            if (t >= n) break;
            start = t;
            run   = 0;
            while (run < D && start + 1 + run < n && u[start+1+run] == 0) run++;
            if (run < D) begin
                // bounce: busy from first low read until the high read
                for (int j = start; j <= start + run && j < n; j++) bz[j] = 1;
                t = start + run + 2;
                continue;
            end
            h = start + D;
            for (int j = start; j < h; j++) bz[j] = 1;
            acc[h] = 1;
            w = h + H;  // first release-wait step
            for (int j = h; j <= w && j < n; j++) begin
                bz[j] = 1;
                hi[j] = 1;
            end
            done = 0;
            while (!done) begin
                s = w + 1;
                while (s < n && u[s] == 0) begin
                    bz[s] = 1;
                    hi[s] = 1;
                    s++;
                end
                if (s >= n) begin
                    t = n;
                    done = 1;
                end else begin
                    bz[s] = 1;
                    hi[s] = 1;
                    k = 1;
                    while (k <= D && s + k < n && u[s+k] == 1) k++;
                    if (k > D) begin
                        for (int j = s + 1; j < s + D; j++) begin
                            bz[j] = 1;
                            hi[j] = 1;
                        end
                        t = s + D + 1;
                        done = 1;
                    end else if (s + k >= n) begin
                        for (int j = s + 1; j < n; j++) begin
                            bz[j] = 1;
                            hi[j] = 1;
                        end
                        t = n;
                        done = 1;
                    end else begin
                        for (int j = s + 1; j <= s + k; j++) begin
                            bz[j] = 1;
                            hi[j] = 1;
                        end
                        w = s + k;
                    end
                end
            end
        end
        exp_arr.delete();
        for (int i = 0; i < n; i++) begin
            if (acc[i] != 0) begin
                m_count = (m_count + 1) % 256;
                m_tog   = ~m_tog;
            end
`ifdef DELAY_CTRL_TOGGLE_EN
            e = m_tog;
`else
            e = (hi[i] != 0);
`endif
            exp_arr.push_back(pack(e, bz[i] != 0, m_count));
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic add_seg(logic v, int len);
        for (int i = 0; i < len; i++) wave.push_back(v);
    endtask

    task automatic run_scenario(string name, bit release_rst);
        scen = name;
        build_expected();
        for (int i = 0; i < wave.size(); i++) begin
            @(negedge clk);
            if (i == 0 && release_rst) rst = 1'b0;
            key_n = wave[i];
            exp_q.push_back(exp_arr[i]);
        end
        @(posedge clk);
        #2;
        wave.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst   = 1'b1;
        key_n = 1'b1;
        repeat (3) @(negedge clk);
        rst     = 1'b0;
        m_count = 0;
        m_tog   = 1'b0;
    endtask

    // ---------------- monitor ----------------
    always @(posedge clk) begin
        logic [9:0] want;
        #1;
        cyc++;
        if (exp_q.size() > 0) begin
            want = exp_q.pop_front();
            check(scen, {dce, busy, pc}, want);
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish, want finish before time limit");
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin
        int nseg;
        rst   = 1'b1;
        key_n = 1'b1;
        repeat (3) @(negedge clk);

        // reset state while idle
        add_seg(1'b1, 6);
        run_scenario("reset_idle", 1'b1);

        add_seg(1'b0, 30);
        add_seg(1'b1, 20);
        run_scenario("clean_press", 1'b0);

        add_seg(1'b0, 3);
        add_seg(1'b1, 15);
        run_scenario("bounce", 1'b0);

        add_seg(1'b0, 6);
        add_seg(1'b1, 25);
        run_scenario("short_press", 1'b0);

        add_seg(1'b0, 20);
        add_seg(1'b1, 2);
        add_seg(1'b0, 2);
        add_seg(1'b1, 20);
        run_scenario("release_bounce", 1'b0);

        for (int r = 0; r < 20; r++) begin
            nseg = $urandom_range(2, 6);
            for (int g = 0; g < nseg; g++) begin
                add_seg(1'b0, $urandom_range(1, 14));
                add_seg(1'b1, $urandom_range(1, 14));
            end
            add_seg(1'b1, 24);
            run_scenario("random", 1'b0);
        end

        // reset in the middle of HOLD, key kept low through reset release
        do_reset();
        scen = "mid_hold";
        @(negedge clk);
        key_n = 1'b0;
        repeat (10) @(negedge clk);
        check("in_hold", {dce, busy, pc}, pack(1'b1, 1'b1, 1));
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("reset_mid_hold", {dce, busy, pc}, pack(1'b0, 1'b0, 0));
        m_count = 0;
        m_tog   = 1'b0;
        add_seg(1'b0, 10);
        add_seg(1'b1, 20);
        run_scenario("held_through_reset", 1'b1);

        // 256 accepted presses wrap the counter back to zero
        do_reset();
        for (int p = 0; p < 256; p++) begin
            add_seg(1'b0, 6);
            add_seg(1'b1, 16);
            run_scenario("wrap", 1'b0);
        end
        check("wrap_final", {dce, busy, pc}, pack(1'b0, 1'b0, 0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
